// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode
// groups, function fields and datapath select encodings.
package multicycle_controller_pkg;

    // Controller FSM states.
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXEC      = 3'd2,
        ST_MEMACC    = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

    // Instruction classes recovered from the opcode high bits.
    typedef enum logic [2:0] {
        IT_REG    = 3'd0,
        IT_IMM    = 3'd1,
        IT_MEM    = 3'd2,
        IT_BRANCH = 3'd3,
        IT_SHIFT  = 3'd4,
        IT_JUMP   = 3'd5,
        IT_UNDEF  = 3'd6
    } itype_t;

    // Opcode group prefixes (compared against instruction[5:4], [5:3], [5:2]).
    localparam logic [1:0] OPC_REG    = 2'b00;
    localparam logic [1:0] OPC_IMM    = 2'b01;
    localparam logic [2:0] OPC_MEM    = 3'b100;
    localparam logic [2:0] OPC_BRANCH = 3'b101;
    localparam logic [2:0] OPC_SHIFT  = 3'b110;
    localparam logic [3:0] OPC_JUMP   = 4'b1110;
    localparam logic [3:0] OPC_UNDEF  = 4'b1111;

    // Memory function field instruction[2:1]; 2'b1x is a no-op.
    localparam logic [1:0] MEM_FN_LDM = 2'b00;
    localparam logic [1:0] MEM_FN_STM = 2'b01;

    // Branch function field instruction[2:1].
    localparam logic [1:0] BR_FN_BZ  = 2'b00;
    localparam logic [1:0] BR_FN_BC  = 2'b01;
    localparam logic [1:0] BR_FN_BNZ = 2'b10;
    localparam logic [1:0] BR_FN_BNC = 2'b11;

    // PC source select.
    localparam logic [1:0] PC_SRC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_SRC_OFFSET = 2'b01;
    localparam logic [1:0] PC_SRC_CONST  = 2'b10;

    // Register-file write source select.
    localparam logic [1:0] RF_SEL_ALU     = 2'b00;
    localparam logic [1:0] RF_SEL_MEMORY  = 2'b01;
    localparam logic [1:0] RF_SEL_SHIFTER = 2'b10;

    // Classify an opcode from its top four bits (instruction[5:2]).
    function automatic itype_t decode_opcode(input logic [3:0] op_hi);
        itype_t kind;
        if (op_hi[3:2] == OPC_REG) begin
            kind = IT_REG;
        end else if (op_hi[3:2] == OPC_IMM) begin
            kind = IT_IMM;
        end else if (op_hi[3:1] == OPC_MEM) begin
            kind = IT_MEM;
        end else if (op_hi[3:1] == OPC_BRANCH) begin
            kind = IT_BRANCH;
        end else if (op_hi[3:1] == OPC_SHIFT) begin
            kind = IT_SHIFT;
        end else if (op_hi == OPC_JUMP) begin
            kind = IT_JUMP;
        end else begin
            kind = IT_UNDEF;
        end
        return kind;
    endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch condition evaluation on the architectural flag registers.
module branch_cond
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] fn,
    input  logic       c,
    input  logic       z,
    output logic       taken
);

    // Select the flag test named by the branch function field.
    always_comb begin
        taken = 1'b0;
        case (fn)
            BR_FN_BZ:  taken = z;
            BR_FN_BC:  taken = c;
            BR_FN_BNZ: taken = ~z;
            BR_FN_BNC: taken = ~c;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEMACC/WRITEBACK FSM that
// sequences the datapath enables and owns the carry/zero flag registers.
// Outputs are decoded from the current state (plus mem_ready for handshake
// completion) and forced low while reset is asserted.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] instruction,
    input  logic       c_alu,
    input  logic       z_alu,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       sel_ALUScr_const,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] rf_in_sel,
    output logic       RegisterFileWriteEn,
    output logic       sel_RegisterFileReadReg2_rd,
    output logic       sel_Cin_shifter,
    output logic       c,
    output logic       z
);

    state_t     state_r;
    state_t     state_next_s;
    itype_t     itype_s;
    logic [1:0] fn_s;
    logic       is_ldm_s;
    logic       is_stm_s;
    logic       branch_taken_s;
    logic       flag_load_s;

    // Instruction is stable from DECODE onward, so decode it continuously.
    assign itype_s  = decode_opcode(instruction[5:2]);
    assign fn_s     = instruction[2:1];
    assign is_ldm_s = (fn_s == MEM_FN_LDM);
    assign is_stm_s = (fn_s == MEM_FN_STM);

    branch_cond u_branch_cond (
        .fn    (fn_s),
        .c     (c),
        .z     (z),
        .taken (branch_taken_s)
    );

    // State register; reset returns to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Carry/zero flags load only when an ALU or shift instruction executes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c <= 1'b0;
            z <= 1'b0;
        end else if (flag_load_s) begin
            c <= c_alu;
            z <= z_alu;
        end else begin
            c <= c;
            z <= z;
        end
    end

    // Next-state and control outputs; everything defaults low each cycle.
    always_comb begin
        state_next_s                = state_r;
        flag_load_s                 = 1'b0;
        ir_write                    = 1'b0;
        mdr_write                   = 1'b0;
        pc_write                    = 1'b0;
        pc_src                      = PC_SRC_PLUS1;
        alu_op                      = 3'b000;
        sel_ALUScr_const            = 1'b0;
        MemRead                     = 1'b0;
        MemWrite                    = 1'b0;
        rf_in_sel                   = RF_SEL_ALU;
        RegisterFileWriteEn         = 1'b0;
        sel_RegisterFileReadReg2_rd = 1'b0;
        sel_Cin_shifter             = 1'b0;

        if (rst) begin
            // Reset silences every strobe, including the FETCH read.
            state_next_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        pc_src       = PC_SRC_PLUS1;
                        state_next_s = ST_DECODE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end

                ST_DECODE: begin
                    case (itype_s)
                        IT_JUMP: begin
                            pc_write     = 1'b1;
                            pc_src       = PC_SRC_CONST;
                            state_next_s = ST_FETCH;
                        end
                        IT_UNDEF: begin
                            state_next_s = ST_FETCH;
                        end
                        default: begin
                            state_next_s = ST_EXEC;
                        end
                    endcase
                end

                ST_EXEC: begin
                    case (itype_s)
                        IT_REG: begin
                            alu_op       = instruction[2:0];
                            flag_load_s  = 1'b1;
                            state_next_s = ST_WRITEBACK;
                        end
                        IT_IMM: begin
                            alu_op           = instruction[2:0];
                            sel_ALUScr_const = 1'b1;
                            flag_load_s      = 1'b1;
                            state_next_s     = ST_WRITEBACK;
                        end
                        IT_SHIFT: begin
                            sel_Cin_shifter = 1'b1;
                            flag_load_s     = 1'b1;
                            state_next_s    = ST_WRITEBACK;
                        end
                        IT_MEM: begin
                            // ALU forms the address from register + constant.
                            sel_ALUScr_const = 1'b1;
                            if (is_ldm_s || is_stm_s) begin
                                state_next_s = ST_MEMACC;
                            end else begin
                                state_next_s = ST_FETCH;
                            end
                        end
                        IT_BRANCH: begin
                            if (branch_taken_s) begin
                                pc_write = 1'b1;
                                pc_src   = PC_SRC_OFFSET;
                            end else begin
                                pc_write = 1'b0;
                            end
                            state_next_s = ST_FETCH;
                        end
                        default: begin
                            state_next_s = ST_FETCH;
                        end
                    endcase
                end

                ST_MEMACC: begin
                    // Address stays selected for the whole access.
                    sel_ALUScr_const = 1'b1;
                    if (is_ldm_s) begin
                        MemRead = 1'b1;
                        if (mem_ready) begin
                            mdr_write    = 1'b1;
                            state_next_s = ST_WRITEBACK;
                        end else begin
                            state_next_s = ST_MEMACC;
                        end
                    end else begin
                        // Store data comes from rd through read port 2.
                        MemWrite                    = 1'b1;
                        sel_RegisterFileReadReg2_rd = 1'b1;
                        if (mem_ready) begin
                            state_next_s = ST_FETCH;
                        end else begin
                            state_next_s = ST_MEMACC;
                        end
                    end
                end

                ST_WRITEBACK: begin
                    RegisterFileWriteEn = 1'b1;
                    case (itype_s)
                        IT_SHIFT: rf_in_sel = RF_SEL_SHIFTER;
                        IT_MEM:   rf_in_sel = RF_SEL_MEMORY;
                        default:  rf_in_sel = RF_SEL_ALU;
                    endcase
                    state_next_s = ST_FETCH;
                end

                default: begin
                    state_next_s = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each scenario pushes
// per-cycle stimulus and the expected output vector into a scoreboard queue,
// then drains it one clock at a time comparing the DUT outputs.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] instruction = 6'd0;
    logic       c_alu = 1'b0;
    logic       z_alu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, mdr_write, pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       sel_ALUScr_const, MemRead, MemWrite;
    logic [1:0] rf_in_sel;
    logic       RegisterFileWriteEn, sel_RegisterFileReadReg2_rd, sel_Cin_shifter;
    logic       c, z;

    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .clk                         (clk),
        .rst                         (rst),
        .instruction                 (instruction),
        .c_alu                       (c_alu),
        .z_alu                       (z_alu),
        .mem_ready                   (mem_ready),
        .ir_write                    (ir_write),
        .mdr_write                   (mdr_write),
        .pc_write                    (pc_write),
        .pc_src                      (pc_src),
        .alu_op                      (alu_op),
        .sel_ALUScr_const            (sel_ALUScr_const),
        .MemRead                     (MemRead),
        .MemWrite                    (MemWrite),
        .rf_in_sel                   (rf_in_sel),
        .RegisterFileWriteEn         (RegisterFileWriteEn),
        .sel_RegisterFileReadReg2_rd (sel_RegisterFileReadReg2_rd),
        .sel_Cin_shifter             (sel_Cin_shifter),
        .c                           (c),
        .z                           (z)
    );

    always #5 clk = ~clk;

    // Output vector: ir mdr pcw pc_src[2] alu_op[3] alc mr mw rf_sel[2] we rd cin c z
    logic [17:0] obs;
    assign obs = {ir_write, mdr_write, pc_write, pc_src, alu_op, sel_ALUScr_const,
                  MemRead, MemWrite, rf_in_sel, RegisterFileWriteEn,
                  sel_RegisterFileReadReg2_rd, sel_Cin_shifter, c, z};

    localparam logic [17:0] B_IR      = 18'h20000;
    localparam logic [17:0] B_MDR     = 18'h10000;
    localparam logic [17:0] B_PCW     = 18'h08000;
    localparam logic [17:0] PCS_CONST = 18'h04000;
    localparam logic [17:0] PCS_OFF   = 18'h02000;
    localparam logic [17:0] B_ALC     = 18'h00200;
    localparam logic [17:0] B_MR      = 18'h00100;
    localparam logic [17:0] B_MW      = 18'h00080;
    localparam logic [17:0] RF_SH     = 18'h00040;
    localparam logic [17:0] RF_MEM    = 18'h00020;
    localparam logic [17:0] B_WE      = 18'h00010;
    localparam logic [17:0] B_RD      = 18'h00008;
    localparam logic [17:0] B_CIN     = 18'h00004;
    localparam logic [17:0] FD        = 18'h28100; // FETCH completing: MR|IR|PCW, pc_src PLUS1

    typedef struct packed {
        logic [5:0]  ins;
        logic        mr;
        logic        ca;
        logic        za;
        logic [17:0] ex;
    } step_t;

    step_t sb_q[$];

    function automatic logic [17:0] fl(input logic cf, input logic zf);
        return {16'd0, cf, zf};
    endfunction

    function automatic logic [17:0] aop(input logic [2:0] a);
        return {5'd0, a, 10'd0};
    endfunction

    task automatic push(input logic [5:0] ins, input logic mr, input logic ca,
                        input logic za, input logic [17:0] ex);
        step_t s;
        s.ins = ins; s.mr = mr; s.ca = ca; s.za = za; s.ex = ex;
        sb_q.push_back(s);
    endtask

    task automatic test_reset();
        mem_ready = 1'b1; c_alu = 1'b1; z_alu = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 18'd0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got %b expected %b", i, obs, 18'd0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Register, immediate and shift instructions back to back; flags start 0,0.
    task automatic test_alu_ops();
        step_t s;
        int n;
        push(6'b000011, 1'b1, 1'b0, 1'b1, FD | fl(1'b0, 1'b0));
        push(6'b000011, 1'b1, 1'b0, 1'b1, fl(1'b0, 1'b0));
        push(6'b000011, 1'b1, 1'b1, 1'b0, aop(3'b011) | fl(1'b0, 1'b0));
        push(6'b000011, 1'b1, 1'b0, 1'b1, B_WE | fl(1'b1, 1'b0));
        push(6'b010101, 1'b1, 1'b1, 1'b0, FD | fl(1'b1, 1'b0));
        push(6'b010101, 1'b1, 1'b1, 1'b0, fl(1'b1, 1'b0));
        push(6'b010101, 1'b1, 1'b0, 1'b1, aop(3'b101) | B_ALC | fl(1'b1, 1'b0));
        push(6'b010101, 1'b1, 1'b1, 1'b0, B_WE | fl(1'b0, 1'b1));
        push(6'b110010, 1'b1, 1'b1, 1'b0, FD | fl(1'b0, 1'b1));
        push(6'b110010, 1'b1, 1'b1, 1'b0, fl(1'b0, 1'b1));
        push(6'b110010, 1'b1, 1'b0, 1'b1, B_CIN | fl(1'b0, 1'b1));
        push(6'b110010, 1'b1, 1'b1, 1'b0, B_WE | RF_SH | fl(1'b0, 1'b1));
        push(6'b110010, 1'b0, 1'b1, 1'b0, B_MR | fl(1'b0, 1'b1));
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            s = sb_q.pop_front();
            instruction = s.ins; mem_ready = s.mr; c_alu = s.ca; z_alu = s.za;
            @(negedge clk);
            checks++;
            if (obs !== s.ex) begin
                errors++;
                $display("FAIL alu_ops step%0d: got %b expected %b", i, obs, s.ex);
            end
            @(posedge clk); #1;
        end
    endtask

    // LDM with three wait cycles in MEMACC; flags stay 0,1.
    task automatic test_ldm_wait();
        step_t s;
        int n;
        push(6'b100000, 1'b1, 1'b1, 1'b0, FD | fl(1'b0, 1'b1));
        push(6'b100000, 1'b1, 1'b1, 1'b0, fl(1'b0, 1'b1));
        push(6'b100000, 1'b1, 1'b1, 1'b0, B_ALC | fl(1'b0, 1'b1));
        for (int k = 0; k < 3; k++) begin
            push(6'b100000, 1'b0, 1'b1, 1'b0, B_ALC | B_MR | fl(1'b0, 1'b1));
        end
        push(6'b100000, 1'b1, 1'b1, 1'b0, B_ALC | B_MR | B_MDR | fl(1'b0, 1'b1));
        push(6'b100000, 1'b1, 1'b1, 1'b0, B_WE | RF_MEM | fl(1'b0, 1'b1));
        push(6'b100000, 1'b0, 1'b1, 1'b0, B_MR | fl(1'b0, 1'b1));
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            s = sb_q.pop_front();
            instruction = s.ins; mem_ready = s.mr; c_alu = s.ca; z_alu = s.za;
            @(negedge clk);
            checks++;
            if (obs !== s.ex) begin
                errors++;
                $display("FAIL ldm_wait step%0d: got %b expected %b", i, obs, s.ex);
            end
            @(posedge clk); #1;
        end
    endtask

    // All four branches with c=0, z=1: BZ taken, BC not, BNZ not, BNC taken.
    task automatic test_branch();
        step_t s;
        int n;
        logic [5:0] ops [4] = '{6'b101000, 6'b101010, 6'b101100, 6'b101110};
        logic       tk  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int b = 0; b < 4; b++) begin
            push(ops[b], 1'b1, 1'b1, 1'b0, FD | fl(1'b0, 1'b1));
            push(ops[b], 1'b1, 1'b1, 1'b0, fl(1'b0, 1'b1));
            push(ops[b], 1'b1, 1'b1, 1'b0,
                 (tk[b] ? (B_PCW | PCS_OFF) : 18'd0) | fl(1'b0, 1'b1));
        end
        push(6'b101110, 1'b0, 1'b1, 1'b0, B_MR | fl(1'b0, 1'b1));
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            s = sb_q.pop_front();
            instruction = s.ins; mem_ready = s.mr; c_alu = s.ca; z_alu = s.za;
            @(negedge clk);
            checks++;
            if (obs !== s.ex) begin
                errors++;
                $display("FAIL branch step%0d: got %b expected %b", i, obs, s.ex);
            end
            @(posedge clk); #1;
        end
    endtask

    // Jump, undefined opcode and memory no-op.
    task automatic test_jump_nop();
        step_t s;
        int n;
        push(6'b111011, 1'b1, 1'b1, 1'b0, FD | fl(1'b0, 1'b1));
        push(6'b111011, 1'b1, 1'b1, 1'b0, B_PCW | PCS_CONST | fl(1'b0, 1'b1));
        push(6'b111110, 1'b1, 1'b1, 1'b0, FD | fl(1'b0, 1'b1));
        push(6'b111110, 1'b1, 1'b1, 1'b0, fl(1'b0, 1'b1));
        push(6'b100110, 1'b1, 1'b1, 1'b0, FD | fl(1'b0, 1'b1));
        push(6'b100110, 1'b1, 1'b1, 1'b0, fl(1'b0, 1'b1));
        push(6'b100110, 1'b1, 1'b1, 1'b0, B_ALC | fl(1'b0, 1'b1));
        push(6'b100110, 1'b0, 1'b1, 1'b0, B_MR | fl(1'b0, 1'b1));
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            s = sb_q.pop_front();
            instruction = s.ins; mem_ready = s.mr; c_alu = s.ca; z_alu = s.za;
            @(negedge clk);
            checks++;
            if (obs !== s.ex) begin
                errors++;
                $display("FAIL jump_nop step%0d: got %b expected %b", i, obs, s.ex);
            end
            @(posedge clk); #1;
        end
    endtask

    // Zero-wait STM, register op and LDM with no idle cycles between them.
    task automatic test_back_to_back();
        step_t s;
        int n;
        push(6'b100011, 1'b1, 1'b0, 1'b0, FD | fl(1'b0, 1'b1));
        push(6'b100011, 1'b1, 1'b0, 1'b0, fl(1'b0, 1'b1));
        push(6'b100011, 1'b1, 1'b0, 1'b0, B_ALC | fl(1'b0, 1'b1));
        push(6'b100011, 1'b1, 1'b0, 1'b0, B_ALC | B_MW | B_RD | fl(1'b0, 1'b1));
        push(6'b000110, 1'b1, 1'b0, 1'b0, FD | fl(1'b0, 1'b1));
        push(6'b000110, 1'b1, 1'b0, 1'b0, fl(1'b0, 1'b1));
        push(6'b000110, 1'b1, 1'b1, 1'b1, aop(3'b110) | fl(1'b0, 1'b1));
        push(6'b000110, 1'b1, 1'b0, 1'b0, B_WE | fl(1'b1, 1'b1));
        push(6'b100001, 1'b1, 1'b0, 1'b0, FD | fl(1'b1, 1'b1));
        push(6'b100001, 1'b1, 1'b0, 1'b0, fl(1'b1, 1'b1));
        push(6'b100001, 1'b1, 1'b0, 1'b0, B_ALC | fl(1'b1, 1'b1));
        push(6'b100001, 1'b1, 1'b0, 1'b0, B_ALC | B_MR | B_MDR | fl(1'b1, 1'b1));
        push(6'b100001, 1'b1, 1'b0, 1'b0, B_WE | RF_MEM | fl(1'b1, 1'b1));
        push(6'b100001, 1'b0, 1'b0, 1'b0, B_MR | fl(1'b1, 1'b1));
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            s = sb_q.pop_front();
            instruction = s.ins; mem_ready = s.mr; c_alu = s.ca; z_alu = s.za;
            @(negedge clk);
            checks++;
            if (obs !== s.ex) begin
                errors++;
                $display("FAIL back_to_back step%0d: got %b expected %b", i, obs, s.ex);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset asserted while an STM waits in MEMACC; flags are 1,1 beforehand.
    task automatic test_reset_stm();
        step_t s;
        int n;
        push(6'b100010, 1'b1, 1'b0, 1'b0, FD | fl(1'b1, 1'b1));
        push(6'b100010, 1'b1, 1'b0, 1'b0, fl(1'b1, 1'b1));
        push(6'b100010, 1'b1, 1'b0, 1'b0, B_ALC | fl(1'b1, 1'b1));
        push(6'b100010, 1'b0, 1'b0, 1'b0, B_ALC | B_MW | B_RD | fl(1'b1, 1'b1));
        push(6'b100010, 1'b0, 1'b0, 1'b0, B_ALC | B_MW | B_RD | fl(1'b1, 1'b1));
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            s = sb_q.pop_front();
            instruction = s.ins; mem_ready = s.mr; c_alu = s.ca; z_alu = s.za;
            @(negedge clk);
            checks++;
            if (obs !== s.ex) begin
                errors++;
                $display("FAIL reset_stm step%0d: got %b expected %b", i, obs, s.ex);
            end
            @(posedge clk); #1;
        end
        // Mid-cycle asynchronous reset while still in MEMACC.
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL reset_async_drop: got %b expected %b", obs, 18'd0);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, 18'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== B_MR) begin
            errors++;
            $display("FAIL reset_release_fetch: got %b expected %b", obs, B_MR);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_ldm_wait();
        test_branch();
        test_jump_nop();
        test_back_to_back();
        test_reset_stm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against the run never finishing.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
